prog_loader: RTL and testbench

Front-end writer for the processor's program memory. The processor core only reads 16-bit instruction words, addressed by PC. This block fills that memory from the board: the operator enters bytes on SW[7:0] and strobes them in with a push-button. Each pair of bytes is packed into one instruction word and written at an auto-incrementing address. The core is held in reset until the run button is pressed.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_key_edge.sv | 34 +++
 rtl/prog_loader.sv | 118 +++++++++++
 tb/tb_prog_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared processor definitions: instruction format and loader FSM encoding.
package prog_loader_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;

    typedef enum logic [2:0] {
        StLoadHi = 3'd0,
        StLoadLo = 3'd1,
        StWrite  = 3'd2,
        StFull   = 3'd3,
        StRun    = 3'd4
    } loader_state_e;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(
        input logic [INSTR_W-1:0] instr
    );
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/prog_loader_key_edge.sv
// Push-button conditioning: 2-flop synchronizer and registered press-edge pulse.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic strobe
);

    logic       sync1_q, sync2_q, prev_q, armed_q;
    logic [1:0] settle_q;

    // Strobes stay disarmed until the synchronizer holds a post-reset sample
    // of a released key, so a key held down through reset is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            armed_q  <= 1'b0;
            settle_q <= 2'd0;
            strobe   <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            armed_q <= armed_q | ((settle_q == 2'd2) & sync2_q);
            strobe  <= armed_q & prev_q & ~sync2_q;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program memory loader: packs operator-entered byte pairs into instruction words
// written at an auto-incrementing address, holding the core in reset until run.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  sw_byte,
    input  logic               key_byte_n,
    input  logic               key_run_n,
    output logic               pmem_we,
    output logic [ADDR_W-1:0]  pmem_addr,
    output logic [INSTR_W-1:0] pmem_data,
    output logic               cpu_rst,
    output logic               loading,
    output logic               hi_pending,
    output logic               full,
    output logic [ADDR_W:0]    word_count
);

    localparam logic [ADDR_W-1:0] AddrMax = '1;

    logic byte_stb, run_stb;

    loader_state_e     state_q, state_d;
    logic [BYTE_W-1:0] hi_q, lo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;

    key_edge u_key_byte (
        .clk    (clk),
        .rst    (rst),
        .key_n  (key_byte_n),
        .strobe (byte_stb)
    );

    key_edge u_key_run (
        .clk    (clk),
        .rst    (rst),
        .key_n  (key_run_n),
        .strobe (run_stb)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoadHi: begin
                // Run wins over a simultaneous byte press.
                if (run_stb) begin
                    state_d = StRun;
                end else if (byte_stb) begin
                    state_d = StLoadLo;
                end
            end
            StLoadLo: begin
                if (byte_stb) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = (addr_q == AddrMax) ? StFull : StLoadHi;
            end
            StFull: begin
                if (run_stb) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StLoadHi;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoadHi;
            hi_q       <= '0;
            lo_q       <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            pmem_we    <= 1'b0;
            cpu_rst    <= 1'b1;
            loading    <= 1'b1;
            hi_pending <= 1'b0;
            full       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StLoadHi && byte_stb && !run_stb) begin
                hi_q <= sw_byte;
            end
            if (state_q == StLoadLo && byte_stb) begin
                lo_q <= sw_byte;
            end
            // Address saturates at the last word; the count reaches capacity.
            if (state_q == StWrite) begin
                count_q <= count_q + (ADDR_W + 1)'(1);
                if (addr_q != AddrMax) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            pmem_we    <= (state_d == StWrite);
            cpu_rst    <= (state_d != StRun);
            loading    <= (state_d == StLoadHi) || (state_d == StLoadLo) || (state_d == StWrite);
            hi_pending <= (state_d == StLoadLo);
            full       <= (state_d == StFull);
        end
    end

    assign pmem_addr  = addr_q;
    assign pmem_data  = {hi_q, lo_q};
    assign word_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table-driven press sequences, directed timing corners and
// random presses checked against a press-level model, on 256-word and 4-word builds.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  sw_byte;
    logic        key_byte_n, key_run_n;

    logic        a_we, a_crst, a_load, a_hp, a_full;
    logic [7:0]  a_addr;
    logic [15:0] a_data;
    logic [8:0]  a_cnt;

    logic        b_we, b_crst, b_load, b_hp, b_full;
    logic [1:0]  b_addr;
    logic [15:0] b_data;
    logic [2:0]  b_cnt;

    prog_loader #(.ADDR_W(8)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .sw_byte    (sw_byte),
        .key_byte_n (key_byte_n),
        .key_run_n  (key_run_n),
        .pmem_we    (a_we),
        .pmem_addr  (a_addr),
        .pmem_data  (a_data),
        .cpu_rst    (a_crst),
        .loading    (a_load),
        .hi_pending (a_hp),
        .full       (a_full),
        .word_count (a_cnt)
    );

    prog_loader #(.ADDR_W(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .sw_byte    (sw_byte),
        .key_byte_n (key_byte_n),
        .key_run_n  (key_run_n),
        .pmem_we    (b_we),
        .pmem_addr  (b_addr),
        .pmem_data  (b_data),
        .cpu_rst    (b_crst),
        .loading    (b_load),
        .hi_pending (b_hp),
        .full       (b_full),
        .word_count (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    // kind: 0 byte press, 1 run press, 2 both keys together, 3 reset
    typedef struct {
        int          kind;
        logic [7:0]  sw;
        int          hold;
        int          we;
        int          addr;
        logic [15:0] data;
        logic        hp;
        logic        crst;
        int          cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int we_long = 0;

    wr_t q_a[$], q_b[$], e_a[$], e_b[$];
    logic a_we_prev = 1'b0, b_we_prev = 1'b0;

    // Press-level model, one slot per build
    int         m_words[2];
    bit         m_hv[2];
    logic [7:0] m_hi[2];
    bit         m_run[2];
    int         m_cap[2];

    always @(negedge clk) begin
        if (a_we === 1'b1) q_a.push_back('{int'(a_addr), a_data});
        if (b_we === 1'b1) q_b.push_back('{int'(b_addr), b_data});
        if (a_we === 1'b1 && a_we_prev === 1'b1) we_long++;
        if (b_we === 1'b1 && b_we_prev === 1'b1) we_long++;
        a_we_prev = a_we;
        b_we_prev = b_we;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_words[d] = 0;
            m_hv[d]    = 1'b0;
            m_hi[d]    = 8'h00;
            m_run[d]   = 1'b0;
        end
    endtask

    task automatic model_press(input int kind, input logic [7:0] v);
        for (int d = 0; d < 2; d++) begin
            bit  as_byte;
            wr_t w;
            as_byte = (kind == 0) || (kind == 2 && m_hv[d]);
            if (!m_run[d]) begin
                if (!as_byte) begin
                    if (!m_hv[d]) m_run[d] = 1'b1;
                end else if (m_words[d] < m_cap[d]) begin
                    if (!m_hv[d]) begin
                        m_hv[d] = 1'b1;
                        m_hi[d] = v;
                    end else begin
                        w.addr = m_words[d];
                        w.data = {m_hi[d], v};
                        if (d == 0) e_a.push_back(w);
                        else e_b.push_back(w);
                        m_words[d]++;
                        m_hv[d] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs(input int d, input string p, input logic crst,
                                 input logic hp, input logic fl, input logic ld,
                                 input int cnt, input int addr);
        int exp_addr;
        exp_addr = (m_words[d] < m_cap[d]) ? m_words[d] : m_cap[d] - 1;
        chk({p, "cpu_rst"}, crst, !m_run[d]);
        chk({p, "hi_pending"}, hp, m_hv[d] && !m_run[d]);
        chk({p, "full"}, fl, (m_words[d] == m_cap[d]) && !m_run[d]);
        chk({p, "loading"}, ld, (m_words[d] < m_cap[d]) && !m_run[d]);
        chk({p, "word_count"}, cnt, m_words[d]);
        chk({p, "pmem_addr"}, addr, exp_addr);
    endtask

    task automatic compare_all();
        wr_t o, e;
        chk("a_num_writes", q_a.size(), e_a.size());
        while (q_a.size() > 0 && e_a.size() > 0) begin
            o = q_a.pop_front();
            e = e_a.pop_front();
            chk("a_wr_addr", o.addr, e.addr);
            chk("a_wr_data", o.data, e.data);
        end
        chk("b_num_writes", q_b.size(), e_b.size());
        while (q_b.size() > 0 && e_b.size() > 0) begin
            o = q_b.pop_front();
            e = e_b.pop_front();
            chk("b_wr_addr", o.addr, e.addr);
            chk("b_wr_data", o.data, e.data);
        end
        q_a.delete(); e_a.delete(); q_b.delete(); e_b.delete();
        check_outputs(0, "a_", a_crst, a_hp, a_full, a_load, int'(a_cnt), int'(a_addr));
        check_outputs(1, "b_", b_crst, b_hp, b_full, b_load, int'(b_cnt), int'(b_addr));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_a_we", a_we, 1'b0);
        chk("rst_a_cpu_rst", a_crst, 1'b1);
        chk("rst_a_loading", a_load, 1'b1);
        chk("rst_a_hi_pending", a_hp, 1'b0);
        chk("rst_a_full", a_full, 1'b0);
        chk("rst_a_count", a_cnt, 9'd0);
        chk("rst_a_addr", a_addr, 8'd0);
        chk("rst_a_data", a_data, 16'h0000);
        chk("rst_b_cpu_rst", b_crst, 1'b1);
        chk("rst_b_count", b_cnt, 3'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_reset();
        q_a.delete(); e_a.delete(); q_b.delete(); e_b.delete();
    endtask

    task automatic press(input int kind, input logic [7:0] v, input int hold);
        @(posedge clk); #1;
        sw_byte = v;
        if (kind != 1) key_byte_n = 1'b0;
        if (kind != 0) key_run_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        key_byte_n = 1'b1;
        key_run_n  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic apply(input int kind, input logic [7:0] v, input int hold);
        if (kind == 3) begin
            do_reset();
        end else begin
            press(kind, v, hold);
            model_press(kind, v);
        end
    endtask

    function automatic vec_t mk(input int kind, input logic [7:0] sw, input int hold,
                                input int we, input int addr, input logic [15:0] data,
                                input logic hp, input logic crst, input int cnt);
        vec_t v;
        v.kind = kind; v.sw = sw; v.hold = hold; v.we = we; v.addr = addr;
        v.data = data; v.hp = hp; v.crst = crst; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[21];

    initial begin
        wr_t w;
        m_cap[0] = 256;
        m_cap[1] = 4;
        model_reset();
        rst = 1'b1; sw_byte = 8'h00; key_byte_n = 1'b1; key_run_n = 1'b1;

        tbl[0]  = mk(3, 8'h00,    2, 0, 0, 16'h0000, 1'b0, 1'b1, 0);
        tbl[1]  = mk(0, 8'h14,    2, 0, 0, 16'h0000, 1'b1, 1'b1, 0);
        tbl[2]  = mk(0, 8'h2A,    2, 1, 0, 16'h142A, 1'b0, 1'b1, 1);
        tbl[3]  = mk(3, 8'h00,    2, 0, 0, 16'h0000, 1'b0, 1'b1, 0);
        tbl[4]  = mk(0, 8'h11,    2, 0, 0, 16'h0000, 1'b1, 1'b1, 0);
        tbl[5]  = mk(0, 8'h05,    2, 1, 0, 16'h1105, 1'b0, 1'b1, 1);
        tbl[6]  = mk(0, 8'h21,    3, 0, 0, 16'h0000, 1'b1, 1'b1, 1);
        tbl[7]  = mk(0, 8'h00,    3, 1, 1, 16'h2100, 1'b0, 1'b1, 2);
        tbl[8]  = mk(0, 8'hB1,    2, 0, 0, 16'h0000, 1'b1, 1'b1, 2);
        tbl[9]  = mk(0, 8'h00,    2, 1, 2, 16'hB100, 1'b0, 1'b1, 3);
        tbl[10] = mk(1, 8'h00,    2, 0, 0, 16'h0000, 1'b0, 1'b0, 3);
        tbl[11] = mk(0, 8'h55,    2, 0, 0, 16'h0000, 1'b0, 1'b0, 3);
        tbl[12] = mk(3, 8'h00,    2, 0, 0, 16'h0000, 1'b0, 1'b1, 0);
        tbl[13] = mk(0, 8'h4F,    2, 0, 0, 16'h0000, 1'b1, 1'b1, 0);
        tbl[14] = mk(1, 8'h4F,    2, 0, 0, 16'h0000, 1'b1, 1'b1, 0);
        tbl[15] = mk(0, 8'h01,    2, 1, 0, 16'h4F01, 1'b0, 1'b1, 1);
        tbl[16] = mk(3, 8'h00,    2, 0, 0, 16'h0000, 1'b0, 1'b1, 0);
        tbl[17] = mk(2, 8'h77,    2, 0, 0, 16'h0000, 1'b0, 1'b0, 0);
        tbl[18] = mk(3, 8'h00,    2, 0, 0, 16'h0000, 1'b0, 1'b1, 0);
        tbl[19] = mk(0, 8'h12,    1, 0, 0, 16'h0000, 1'b1, 1'b1, 0);
        tbl[20] = mk(0, 8'h34, 1000, 1, 0, 16'h1234, 1'b0, 1'b1, 1);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].kind, tbl[i].sw, tbl[i].hold);
            chk($sformatf("tbl%0d_nwr", i), q_a.size(), tbl[i].we);
            if (tbl[i].we != 0 && q_a.size() > 0) begin
                w = q_a[0];
                chk($sformatf("tbl%0d_addr", i), w.addr, tbl[i].addr);
                chk($sformatf("tbl%0d_data", i), w.data, tbl[i].data);
            end
            chk($sformatf("tbl%0d_hi_pending", i), a_hp, tbl[i].hp);
            chk($sformatf("tbl%0d_cpu_rst", i), a_crst, tbl[i].crst);
            chk($sformatf("tbl%0d_count", i), a_cnt, tbl[i].cnt);
            compare_all();
        end

        // Cycle-exact: key sampled low at edge N, write pulse after edge N+3.
        do_reset();
        apply(0, 8'hC3, 2);
        @(posedge clk); #1;
        sw_byte = 8'h5A;
        key_byte_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lat_we_early", a_we, 1'b0);
        key_byte_n = 1'b1;
        @(posedge clk); #1;
        chk("lat_we_pulse", a_we, 1'b1);
        chk("lat_data", a_data, 16'hC35A);
        chk("lat_count_before", a_cnt, 9'd0);
        @(posedge clk); #1;
        chk("lat_we_end", a_we, 1'b0);
        chk("lat_count_after", a_cnt, 9'd1);
        chk("lat_addr_after", a_addr, 8'd1);
        model_press(0, 8'h5A);
        repeat (4) @(posedge clk);
        #1;
        compare_all();

        // cpu_rst falls 3 edges after the run key is sampled low.
        @(posedge clk); #1;
        key_run_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("run_cpu_rst_held", a_crst, 1'b1);
        key_run_n = 1'b1;
        @(posedge clk); #1;
        chk("run_cpu_rst_fall", a_crst, 1'b0);
        model_press(1, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        compare_all();

        // Reset mid-word, then a key held low across reset release.
        apply(3, 8'h00, 2);
        apply(0, 8'h99, 2);
        compare_all();
        key_byte_n = 1'b0;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        key_byte_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("held_rst_no_strobe", a_hp, 1'b0);
        compare_all();

        // Small build fills after 4 words; further words go only to the large build.
        for (int i = 0; i < 8; i++) apply(0, 8'(8'h10 + i), 2);
        chk("b_full_flag", b_full, 1'b1);
        chk("b_full_count", b_cnt, 3'd4);
        chk("b_full_addr", b_addr, 2'd3);
        compare_all();
        apply(0, 8'hE0, 2);
        apply(0, 8'hE1, 2);
        compare_all();
        apply(1, 8'h00, 2);
        chk("b_full_run", b_crst, 1'b0);
        compare_all();

        // Random presses against the model.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            int r, kind;
            r = $urandom_range(0, 99);
            kind = (r < 82) ? 0 : (r < 90) ? 1 : (r < 94) ? 2 : 3;
            apply(kind, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
            compare_all();
        end

        chk("we_single_cycle", we_long, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
